twos_complement_negator_seq: RTL
================================

Name: twos_complement_negator_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 32-bit bitwise flipper.
- Computes ones' complement, two's-complement negation, absolute value or pass-through of a WIDTH-bit operand.
- Processes CHUNK bits per cycle with a registered carry, so wide operands do not need a full-width incrementer.
- Sits beside the ALU and multdiv unit as a shared sign-conditioning resource with a start/ready/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CHUNK, 8, bits processed per RUN cycle. Must divide WIDTH evenly; CHUNK=WIDTH is legal. N = WIDTH/CHUNK.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- mode  input  2  00 ones' complement, 01 two's negate, 10 absolute value, 11 pass-through. Sampled with start.
- data_in  input  WIDTH  operand. Sampled with start.
- ready  output  1  high only in IDLE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- data_out  output  WIDTH  result register.
- overflow  output  1  result not representable; registered with the result.

Behaviour:
- Reset (reset=1 at an edge), any state:
  - state=IDLE, chunk counter=0, carry=0, working register=0.
  - data_out=0, overflow=0, done=0, busy=0, ready=1.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - At an edge with start=1, latch data_in and mode into internal registers.
  - Counter=0; state->RUN.
  - Initial carry = 1 for mode 01, and for mode 10 when data_in[WIDTH-1]=1; otherwise 0.
  - Invert flag = 1 for mode 00, mode 01, and mode 10 when the MSB is 1; otherwise 0.
- RUN, edge with counter=k:
  - Working chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) <= (chunk XOR {CHUNK{invert}}) + carry.
  - Carry <= carry-out of that chunk addition. Counter increments.
  - On the edge where k=N-1: copy the full result to data_out, register overflow, set done=1, state->DONE.
  - Final carry-out is discarded (e.g. negate 0 -> 0, no overflow).
- DONE: lasts one cycle. done=1, ready=0. Next edge: done=0, state->IDLE.
- Latency: start accepted at edge E0. done is high in the cycle after edge EN, i.e. N+1 edges after acceptance. Throughput is one operation per N+2 cycles.
- overflow = 1 only when mode is 01 or 10 and the operand is 1 followed by WIDTH-1 zeros. The result then equals the operand. Modes 00 and 11 always give overflow=0.
- Mode 11: invert=0 and carry=0; the result equals the operand after the same N+1 latency.
- start while busy or in DONE: ignored. No queuing, and latched operands are unaffected.
- data_in and mode changing after acceptance have no effect.
- data_out and overflow hold their last values from DONE until the next completion or reset. They are never updated during RUN.
- ready = (state==IDLE); busy = (state==RUN). Both are decoded from registered state, glitch-free.

Test Plan (WIDTH=32, CHUNK=8 unless stated):
- Assert reset for 2 cycles, release -> ready=1, busy=0, done=0, data_out=0x00000000, overflow=0.
- mode=00, data_in=0x00000000, start one cycle -> busy for 4 cycles; done pulses exactly once, 5 edges after acceptance; data_out=0xFFFFFFFF, overflow=0.
- mode=01 with data_in=0x00000005 -> 0xFFFFFFFB. mode=01 with 0x00000000 -> 0x00000000, overflow=0. mode=01 with 0x80000000 -> 0x80000000, overflow=1.
- mode=10 with 0xFFFFFFF6 -> 0x0000000A. mode=10 with 0x0000000A -> 0x0000000A. mode=11 with 0x12345678 -> 0x12345678. overflow=0 in all three.
- Start negate 0x00000001, then pulse start with 0xDEADBEEF during RUN -> second request ignored; result 0xFFFFFFFF; done pulses once.
- Assert reset at the 2nd RUN cycle -> IDLE next edge, no done, data_out=0. Repeat the negate test with CHUNK=32 -> done 2 edges after acceptance, same results.

Source files
------------

// File: rtl/twos_complement_negator_seq.sv
// ---------------------------------------------------------------------------
// twos_complement_negator_seq
//
// Shared sign-conditioning unit. It produces the ones' complement, the two's
// complement negation, the absolute value, or a pass-through copy of a
// WIDTH-bit operand. The operand is processed CHUNK bits per cycle with a
// registered carry, so no full-width incrementer is needed.
//
// Ports:
//   clock     in   single clock, rising edge
//   reset     in   synchronous, active-high reset
//   start     in   request, accepted only while ready=1
//   mode      in   2'b00 ones' complement, 2'b01 negate,
//                  2'b10 absolute value, 2'b11 pass-through
//   data_in   in   operand (sampled together with start)
//   ready     out  unit idle, a start will be accepted
//   busy      out  chunk processing in progress
//   done      out  one-cycle pulse, data_out/overflow just updated
//   data_out  out  result register, holds until the next completion
//   overflow  out  result not representable (negating the most negative value)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operand and derived flags latched on accept
// RUN   | one chunk per cycle: chunk <= (chunk ^ invert) + carry
// DONE  | single cycle with done=1, then back to IDLE
// ---------------------------------------------------------------------------
module twos_complement_negator_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               invert_q, invert_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               overflow_q, overflow_d;

    logic [CHUNK-1:0]   cur_chunk;
    logic [CHUNK:0]     chunk_sum;
    logic               last_chunk;
    logic               neg_op;
    logic               is_min;

    // Select the chunk addressed by the counter.
    always_comb begin
        cur_chunk = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                cur_chunk = work_q[k*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_sum  = {1'b0, cur_chunk ^ {CHUNK{invert_q}}} + {{CHUNK{1'b0}}, carry_q};
    assign last_chunk = (cnt_q == CNT_W'(N - 1));

    // Negation is needed for mode 01 always, and for mode 10 on a negative operand.
    assign neg_op = (mode == 2'b01) || ((mode == 2'b10) && data_in[WIDTH-1]);
    assign is_min = (data_in == {1'b1, {(WIDTH-1){1'b0}}});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        invert_d   = invert_q;
        ovf_pend_d = ovf_pend_q;
        work_d     = work_q;
        data_out_d = data_out_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d     = data_in;
                    cnt_d      = '0;
                    carry_d    = neg_op;
                    invert_d   = (mode == 2'b00) || neg_op;
                    // Only the most negative value cannot be negated; the
                    // chunked add then wraps back to the operand itself.
                    ovf_pend_d = ((mode == 2'b01) || (mode == 2'b10)) && is_min;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        work_d[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                    end
                end
                carry_d = chunk_sum[CHUNK];
                if (last_chunk) begin
                    // Final carry-out is dropped: it is only the wrap of the top chunk.
                    cnt_d      = '0;
                    data_out_d = work_d;
                    overflow_d = ovf_pend_q;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            invert_q   <= 1'b0;
            ovf_pend_q <= 1'b0;
            work_q     <= '0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            invert_q   <= invert_d;
            ovf_pend_q <= ovf_pend_d;
            work_q     <= work_d;
            data_out_q <= data_out_d;
            overflow_q <= overflow_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign data_out = data_out_q;
    assign overflow = overflow_q;

endmodule
